// File: rtl/phy_types_pkg.sv
// phy_types_pkg: shared PHY types for the chip-to-chip lane.
//   comma_length_sel_t : how many 10-bit symbols of a flit are transmitted
//   flit_enc_t         : encoded flit {meta_data[9:0], word[39:0]}
//   uart_tx_state_t    : UART transmit serializer states
//   comma_sel_to_nsym  : symbol count for a comma selection (0 for NADA)
// Optional feature macro: PHY_UART_PARITY_EN (adds an even-parity bit per frame).
package phy_types_pkg;

  typedef enum logic [1:0] {
    NADA                = 2'd0,
    SELECT_COMMA_1_FLIT = 2'd1,
    SELECT_COMMA_2_FLIT = 2'd2,
    SELECT_COMMA_DATA   = 2'd3
  } comma_length_sel_t;

  typedef struct packed {
    logic [9:0]  meta_data;
    logic [39:0] word;
  } flit_enc_t;

  localparam int unsigned UART_SYM_W = 10;
`ifdef PHY_UART_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 13;
`else
  localparam int unsigned UART_FRAME_BITS = 12;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic logic [2:0] comma_sel_to_nsym(input comma_length_sel_t sel);
    logic [2:0] n;
    case (sel)
      SELECT_COMMA_1_FLIT: n = 3'd1;
      SELECT_COMMA_2_FLIT: n = 3'd2;
      SELECT_COMMA_DATA:   n = 3'd5;
      default:             n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phy_uart_baud_cnt.sv
// phy_uart_baud_cnt: bit-period timer shared by the UART transmit and receive sides.
//   i_clk      : clock
//   i_rst      : synchronous active-high reset
//   i_clr      : synchronous clear of the count
//   i_en       : advance the count
//   o_bit_tick : high while enabled and the count sits at CLKS_PER_BIT-1
module phy_uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = i_en && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_bit_tick) r_cnt <= '0;
      else            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phy_uart_tx.sv
// phy_uart_tx: serializes encoded flits onto a single-wire UART-style lane.
// Each 10-bit symbol is one frame: start(0), 10 symbol bits LSB first, stop(1).
//   clk         : clock
//   rst         : synchronous active-high reset
//   flit_i      : flit_enc_t {meta_data[9:0], word[39:0]}
//   comma_sel_i : comma_length_sel_t, selects 1, 2 or 5 symbols (NADA is rejected)
//   valid_i     : flit_i/comma_sel_i valid
//   ready_o     : idle, a flit is accepted on valid_i
//   uart_tx_o   : serial line, idles high
//   busy_o      : flit in flight
//   done_o      : pulse during the final cycle of the last stop bit
//   err_o       : pulse the cycle after a NADA flit is accepted and dropped
// Optional feature macro: PHY_UART_PARITY_EN (even parity bit between data and stop).
module phy_uart_tx
  import phy_types_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [49:0] flit_i,
  input  logic [1:0]  comma_sel_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  uart_tx_state_t r_state, w_next;
  flit_enc_t      r_flit;
  logic [2:0]     r_nsym, r_sym_cnt;
  logic [3:0]     r_bit_cnt;
  logic           r_err;

  logic [2:0]            w_nsym;
  logic                  w_accept, w_tick, w_last_bit, w_last_sym;
  logic [UART_SYM_W-1:0] w_sym;

  assign w_nsym     = comma_sel_to_nsym(comma_length_sel_t'(comma_sel_i));
  assign w_accept   = valid_i && (r_state == IDLE);
  assign w_last_bit = (r_bit_cnt == 4'(UART_SYM_W - 1));
  assign w_last_sym = (r_sym_cnt == (r_nsym - 3'd1));

  // Counter is held clear in IDLE so every frame starts at count 0.
  phy_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (r_state == IDLE),
    .i_en       (r_state != IDLE),
    .o_bit_tick (w_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept && (w_nsym != 3'd0)) w_next = START;
      START: if (w_tick) w_next = DATA;
`ifdef PHY_UART_PARITY_EN
      DATA:   if (w_tick && w_last_bit) w_next = PARITY;
      PARITY: if (w_tick) w_next = STOP;
`else
      DATA:  if (w_tick && w_last_bit) w_next = STOP;
`endif
      STOP:  if (w_tick) w_next = w_last_sym ? IDLE : START;
      default: w_next = IDLE;
    endcase
  end

  // Flit capture, bit and symbol counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit    <= '0;
      r_nsym    <= '0;
      r_sym_cnt <= '0;
      r_bit_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && (w_nsym == 3'd0);
      if (w_accept) begin
        r_flit    <= flit_enc_t'(flit_i);
        r_nsym    <= w_nsym;
        r_sym_cnt <= '0;
      end else if ((r_state == STOP) && w_tick) begin
        r_sym_cnt <= r_sym_cnt + 3'd1;
      end
      if (r_state != DATA) r_bit_cnt <= '0;
      else if (w_tick)     r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  always_comb begin
    case (r_sym_cnt)
      3'd0:    w_sym = r_flit.meta_data;
      3'd1:    w_sym = r_flit.word[9:0];
      3'd2:    w_sym = r_flit.word[19:10];
      3'd3:    w_sym = r_flit.word[29:20];
      3'd4:    w_sym = r_flit.word[39:30];
      default: w_sym = '0;
    endcase
  end

  // Output logic
  always_comb begin
    uart_tx_o = 1'b1;
    case (r_state)
      START:   uart_tx_o = 1'b0;
      DATA:    uart_tx_o = w_sym[r_bit_cnt];
      PARITY:  uart_tx_o = ^w_sym;
      default: uart_tx_o = 1'b1;
    endcase
    ready_o = (r_state == IDLE);
    busy_o  = (r_state != IDLE);
    done_o  = (r_state == STOP) && w_tick && w_last_sym;
    err_o   = r_err;
  end

endmodule

// File: tb/tb_phy_uart_tx.sv
module tb_phy_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 12 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [49:0] flit_i;
  logic [1:0]  comma_sel_i;
  logic        valid_i;
  logic        ready_o, uart_tx_o, busy_o, done_o, err_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  bit q_line[$];
  bit q_done[$];
  bit q_ready[$];

  logic [49:0] rx;

  always #5 clk = ~clk;

  phy_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flit_i      (flit_i),
    .comma_sel_i (comma_sel_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".line"},  64'(uart_tx_o), 64'd1);
    chk({tag, ".ready"}, 64'(ready_o),   64'd1);
    chk({tag, ".busy"},  64'(busy_o),    64'd0);
    chk({tag, ".done"},  64'(done_o),    64'd0);
    chk({tag, ".err"},   64'(err_o),     64'd0);
  endtask

  // Expected per-cycle line/done/ready for one flit, starting the cycle after acceptance.
  task automatic push_flit(input logic [9:0] meta, input logic [39:0] word, input int unsigned n);
    logic [9:0] sym;
    bit         b;
    for (int unsigned k = 0; k < n; k++) begin
      sym = (k == 0) ? meta : word[10*(k-1) +: 10];
      for (int unsigned bi = 0; bi < 12; bi++) begin
        if (bi == 0)       b = 1'b0;
        else if (bi == 11) b = 1'b1;
        else               b = sym[bi-1];
        for (int unsigned c = 0; c < CPB; c++) begin
          q_line.push_back(b);
          q_done.push_back((k == n - 1) && (bi == 11) && (c == CPB - 1));
          q_ready.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic push_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      q_line.push_back(1'b1);
      q_done.push_back(1'b0);
      q_ready.push_back(1'b1);
    end
  endtask

  // Walks the expected queues (up to limit entries), checking every cycle; valid_i
  // drops after the edge following entry drop_at. Also recovers symbols by mid-bit sampling.
  task automatic run_queue(input string tag, input int unsigned limit, input int drop_at,
                           output logic [49:0] rx_o);
    logic [9:0]  syms [5];
    int unsigned pos, fr, n;
    for (int unsigned k = 0; k < 5; k++) syms[k] = '0;
    n = (q_line.size() < limit) ? q_line.size() : limit;
    for (int unsigned i = 0; i < n; i++) begin
      chk($sformatf("%s.line[%0d]", tag, i),  64'(uart_tx_o), 64'(q_line[i]));
      chk($sformatf("%s.done[%0d]", tag, i),  64'(done_o),    64'(q_done[i]));
      chk($sformatf("%s.ready[%0d]", tag, i), 64'(ready_o),   64'(q_ready[i]));
      chk($sformatf("%s.busy[%0d]", tag, i),  64'(busy_o),    64'(!q_ready[i]));
      chk($sformatf("%s.err[%0d]", tag, i),   64'(err_o),     64'd0);
      fr  = i / FRAME;
      pos = (i % FRAME) / CPB;
      if ((i % CPB == CPB / 2) && (pos >= 1) && (pos <= 10) && (fr < 5))
        syms[fr][pos-1] = uart_tx_o;
      tick();
      if (int'(i) == drop_at) valid_i = 1'b0;
    end
    rx_o = {syms[0], syms[4], syms[3], syms[2], syms[1]};
    q_line.delete();
    q_done.delete();
    q_ready.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; flit_i = '0; comma_sel_i = 2'd0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("idle[%0d]", i));
    end

    // single-symbol flit carrying START_COMMA
    flit_i = {10'b1100001011, 40'h00_0000_0000}; comma_sel_i = 2'd1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    push_flit(10'b1100001011, 40'h0, 1);
    push_idle(2);
    run_queue("c1", 1000, -1, rx);
    chk("c1.rx_meta", 64'(rx[49:40]), 64'(10'b1100001011));

    // five-symbol data flit, inputs scrambled after acceptance
    flit_i = {10'h17C, 40'hA5_5A_F0_0F_C3}; comma_sel_i = 2'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; flit_i = '1; comma_sel_i = 2'd1;
    push_flit(10'h17C, 40'hA5_5A_F0_0F_C3, 5);
    push_idle(2);
    run_queue("data", 1000, -1, rx);
    chk("data.rx_flit", 64'(rx), 64'({10'h17C, 40'hA5_5A_F0_0F_C3}));

    // back-to-back: 2-symbol then 1-symbol, valid held high throughout
    flit_i = {10'h2AA, 40'h00_0000_0155}; comma_sel_i = 2'd2; valid_i = 1'b1;
    tick();
    flit_i = {10'h0F3, 40'hFF_FFFF_FFFF}; comma_sel_i = 2'd1;
    push_flit(10'h2AA, 40'h00_0000_0155, 2);
    push_idle(1);
    push_flit(10'h0F3, 40'h0, 1);
    push_idle(2);
    run_queue("b2b", 1000, 96, rx);

    // NADA is dropped with an error pulse
    flit_i = {10'h3FF, 40'h12_3456_789A}; comma_sel_i = 2'd0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("nada.err",   64'(err_o),     64'd1);
    chk("nada.ready", 64'(ready_o),   64'd1);
    chk("nada.line",  64'(uart_tx_o), 64'd1);
    chk("nada.busy",  64'(busy_o),    64'd0);
    chk("nada.done",  64'(done_o),    64'd0);
    tick();
    chk_idle("nada.after");
    push_idle(6);
    run_queue("nada.idle", 1000, -1, rx);

    // reset 30 cycles into a data flit
    flit_i = {10'h3C5, 40'h12_3456_789A}; comma_sel_i = 2'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    push_flit(10'h3C5, 40'h12_3456_789A, 5);
    run_queue("pre_rst", 30, -1, rx);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_rst");
    push_idle(8);
    run_queue("post_rst", 1000, -1, rx);

    flit_i = {10'h21B, 40'h00_0000_02E4}; comma_sel_i = 2'd2; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    push_flit(10'h21B, 40'h00_0000_02E4, 2);
    push_idle(2);
    run_queue("after_rst", 1000, -1, rx);
    chk("after_rst.rx_meta", 64'(rx[49:40]), 64'(10'h21B));
    chk("after_rst.rx_sym1", 64'(rx[9:0]),   64'(10'h2E4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
